// File: rtl/modred_pkg.sv
// Shared defaults and helpers for the modular-reduction final correction stage.
// Holds width/depth defaults, the almost-full margin and a clog2 helper.
package modred_pkg;

  localparam int DATA_SIZE_ARB_DEF = 32;
  localparam int W_SIZE_DEF        = 32;
  localparam int TAG_W_DEF         = 8;
  localparam int FIFO_DEPTH_DEF    = 4;

  // Two samples can be in flight in stage 1/stage 2 when upstream stops.
  localparam int AF_MARGIN = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/modred_out_fifo.sv
// Show-ahead output FIFO with occupancy count, full flag and sticky overflow.
// Ports: push/push_data in; valid/ready/head out; count, full, overflow status.
module modred_out_fifo
  import modred_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  output logic                  valid,
  input  logic                  ready,
  output logic [W-1:0]          head,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  overflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;
  logic          wr;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];
  assign pop   = valid & ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
  assign wr    = push & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push & ~wr)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/modred_final_corr.sv
// Final conditional subtraction: maps C in [0,2q) to [0,q), tag carried along.
// Ports: q, in_*, out_* (show-ahead FIFO), fifo_count, almost_full, overflow;
// range_err is present only when MODRED_RANGE_CHK_EN is defined.
module modred_final_corr
  import modred_pkg::*;
#(
  parameter int DATA_SIZE_ARB = DATA_SIZE_ARB_DEF,
  parameter int IN_W          = DATA_SIZE_ARB + 1,
  parameter int TAG_W         = TAG_W_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_SIZE_ARB-1:0]   q,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_SIZE_ARB-1:0]   out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [clog2(FIFO_DEPTH):0] fifo_count,
  output logic                       almost_full,
  output logic                       overflow
`ifdef MODRED_RANGE_CHK_EN
  ,
  output logic                       range_err
`endif
);

  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] AF_LVL = CW'(FIFO_DEPTH - AF_MARGIN);

  logic                     v1;
  logic [IN_W-1:0]          x1;
  logic [IN_W:0]            d1;
  logic [TAG_W-1:0]         tag1;
  logic                     borrow;
  logic [DATA_SIZE_ARB-1:0] res;
  logic                     unused_bits;
  logic                     unused_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      x1   <= '0;
      d1   <= '0;
      tag1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        x1   <= in_data;
        d1   <= {1'b0, in_data} - (IN_W+1)'(q);
        tag1 <= in_tag;
      end
    end
  end

  // Borrow means C < q, so C is already canonical.
  assign borrow = d1[IN_W];
  assign res    = borrow ? x1[DATA_SIZE_ARB-1:0]
                         : d1[DATA_SIZE_ARB-1:0];

  // Upper bits are zero for legal inputs; only the low word is used.
  assign unused_bits = ^{x1[IN_W-1:DATA_SIZE_ARB],
                         d1[IN_W-1:DATA_SIZE_ARB]};

`ifdef MODRED_RANGE_CHK_EN
  logic rng1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rng1      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (in_valid)
        rng1 <= (in_data >= {q, 1'b0});
      if (v1 & rng1)
        range_err <= 1'b1;
    end
  end
`endif

  modred_out_fifo #(
    .W     (DATA_SIZE_ARB + TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (v1),
    .push_data ({res, tag1}),
    .valid     (out_valid),
    .ready     (out_ready),
    .head      ({out_data, out_tag}),
    .count     (fifo_count),
    .full      (unused_full),
    .overflow  (overflow)
  );

  assign almost_full = (fifo_count >= AF_LVL);

endmodule

// File: tb/tb_modred_final_corr.sv
// Self-checking bench for modred_final_corr with q=12289.
// Table vectors plus hand sequences; outputs checked against a queue.
module tb_modred_final_corr;

  localparam int DW = 32;
  localparam int IW = 33;
  localparam int TW = 8;
  localparam int CW = 3;
  localparam logic [DW-1:0] QV = 32'd12289;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] q;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic [CW-1:0] fifo_count;
  logic          almost_full;
  logic          overflow;
`ifdef MODRED_RANGE_CHK_EN
  logic          range_err;
`endif

  always #5 clk = ~clk;

  modred_final_corr dut (
    .clk         (clk),
    .reset       (reset),
    .q           (q),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .fifo_count  (fifo_count),
    .almost_full (almost_full),
    .overflow    (overflow)
`ifdef MODRED_RANGE_CHK_EN
    ,
    .range_err   (range_err)
`endif
  );

  typedef struct {
    logic [IW-1:0] din;
    logic [TW-1:0] tag;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [9];
  logic [DW+TW-1:0] sb [$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // One cycle: compare any handshake at the negedge, return at posedge+1.
  task automatic step();
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        logic [DW+TW-1:0] e;
        e = sb.pop_front();
        chk("out_data", out_data, e[DW+TW-1:TW]);
        chk("out_tag", out_tag, e[TW-1:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [IW-1:0] d, input logic [TW-1:0] t,
                       input logic [DW-1:0] e, input bit keep);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    if (keep) sb.push_back({e, t});
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_done", sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{33'd12289, 8'h01, 32'd0};
    vecs[1] = '{33'd24577, 8'h02, 32'd12288};
    vecs[2] = '{33'd12288, 8'h03, 32'd12288};
    vecs[3] = '{33'd0,     8'h04, 32'd0};
    vecs[4] = '{33'd1,     8'h05, 32'd1};
    vecs[5] = '{33'd12290, 8'h06, 32'd1};
    vecs[6] = '{33'd24000, 8'h07, 32'd11711};
    vecs[7] = '{33'd6144,  8'h08, 32'd6144};
    vecs[8] = '{33'd24576, 8'h09, 32'd12287};

    reset     = 1'b1;
    q         = QV;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
`ifdef MODRED_RANGE_CHK_EN
    chk("rst_range_err", range_err, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Latency: output visible two edges after acceptance.
    out_ready = 1'b1;
    drive(33'd5000, 8'h11, 32'd5000, 1);
    step();
    in_valid = 1'b0;
    chk("lat_e0_valid", out_valid, 0);
    step();
    chk("lat_e1_valid", out_valid, 1);
    chk("lat_e1_data", out_data, 5000);
    chk("lat_e1_tag", out_tag, 8'h11);
    step();

    // Back-to-back table stream.
    foreach (vecs[i]) begin
      drive(vecs[i].din, vecs[i].tag, vecs[i].exp, 1);
      step();
    end
    in_valid = 1'b0;
    drain(20);

    // Fill with consumer stalled; fifth sample must be dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(33'(100 + i), 8'(8'hA0 + i), 32'(100 + i), 1);
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("fill_count", fifo_count, i + 1);
      chk("fill_af", almost_full, (i + 1) >= 2);
      chk("fill_ovf", overflow, 0);
    end
    drive(33'd200, 8'hEE, 32'd200, 0);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_data, 100);
    drain(20);
    chk("ovf_drained", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);

    // Reset clears sticky overflow.
    reset = 1'b1;
    #1;
    chk("rst2_ovf", overflow, 0);
    step();
    reset = 1'b0;
    step();

    // Full FIFO: push and pop in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(33'(300 + i), 8'(8'hB0 + i), 32'(300 + i), 1);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("pp_full_count", fifo_count, 4);
    drive(33'd12296, 8'hC7, 32'd7, 1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_count", fifo_count, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", out_data, 301);
    drain(20);

    // Reset with a sample in stage 1: nothing may emerge afterwards.
    out_ready = 1'b1;
    drive(33'd9999, 8'h55, 32'd9999, 0);
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_af", almost_full, 0);
    chk("mid_rst_ovf", overflow, 0);
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_count", fifo_count, 0);

`ifdef MODRED_RANGE_CHK_EN
    chk("rng_pre", range_err, 0);
    drive(33'd24578, 8'h77, 32'd12289, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("rng_set", range_err, 1);
    repeat (3) step();
    chk("rng_sticky", range_err, 1);
    drain(20);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
